mux_n_seq: RTL
==============

Name: mux_n_seq

Overview:
- Parametrised successor of the fixed 4-input registered mux in the Versat unit library.
- NUM_IN data channels, each DATA_W bits wide; configurable output pipeline depth.
- Two select modes: static select, or an autonomous channel sequencer that steps through a channel window every PERIOD+1 cycles while the accelerator is running.
- Sits in the datapath as a Versat functional unit, driven by the standard run/running control pair.

Parameters:
DATA_W, 32, width of each data channel and of the output
NUM_IN, 8, number of input channels (2..64)
LATENCY, 1, output register stages (>=1); the out0 versat_latency attribute equals LATENCY
PERIOD_W, 8, width of the dwell-period config field
SEL_W, $clog2(NUM_IN), channel index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
running  in  1  accelerator running window
run  in  1  one-cycle start pulse; latches configuration
in_flat  in  DATA_W*NUM_IN  channel k occupies bits [k*DATA_W +: DATA_W]
sel  in  SEL_W  static channel / sequence start channel
mode  in  1  0 = static, 1 = sequence
period  in  PERIOD_W  dwell cycles per channel minus one
seq_end  in  SEL_W  last channel of sequence window
out0  out  DATA_W  selected data, LATENCY cycles after selection
out_valid  out  1  out0 holds data sampled while running
cur_chan  out  SEL_W  channel currently selected (pre-pipeline)

Behaviour:
- Reset (rst=0 at clk edge): out0, every pipeline stage, out_valid, cur_chan, dwell counter and shadow config regs all go to 0. Reset has priority over everything, including mid-sequence.
- Config shadowing:
  - run=1 latches sel, mode, period and seq_end into shadow regs, independent of running.
  - Same edge: cur_chan <= sel, dwell counter <= 0.
  - Config inputs are otherwise ignored; shadow values are held between run pulses.
- Static mode (mode_q=0): cur_chan stays at sel_q.
- Sequence mode (mode_q=1), only while running=1 and run=0:
  - Dwell counter increments each cycle.
  - When counter == period_q: counter <= 0 and cur_chan advances.
  - Advance rule: if cur_chan == end_q, cur_chan <= sel_q; else if cur_chan == NUM_IN-1, cur_chan <= 0; else cur_chan + 1.
  - period_q = 0 advances every cycle.
  - end_q < sel_q wraps through channel NUM_IN-1 to 0.
  - sel_q == end_q holds a single channel.
  - running=0 freezes the counter and cur_chan.
- Simultaneous run and advance condition: run wins; the sequence restarts at the new sel.
- Datapath:
  - Stage 1 captures the data of in_flat at cur_chan's current value every cycle.
  - Each further stage copies the previous one every cycle.
  - out0 is the last stage, so total latency from cur_chan to out0 is LATENCY cycles.
- Valid: a LATENCY-deep shift register of running; out_valid is running delayed by LATENCY cycles. Data still shifts when running=0, but out_valid marks it stale.
- Out-of-range index (cur_chan >= NUM_IN, only possible when NUM_IN is not a power of two): behaviour set by the optional feature below.
- Pipeline stages carry no reset-mid-flight exceptions: reset clears all stages on the same edge.

Optional Feature:
- Macro: MUX_N_SEQ_SEL_CLAMP_EN.
- Defined: an out-of-range cur_chan selects channel NUM_IN-1, and the sequencer's wrap compares against min(end_q, NUM_IN-1).
- Undefined: an out-of-range cur_chan selects all-zero data; the sequencer logic is unchanged and may dwell on the out-of-range index until the wrap rule returns it to range.
- With NUM_IN a power of two, both builds are identical.

Decomposition:
- Shared package mux_n_seq_pkg:
  - MODE_STATIC = 1'b0, MODE_SEQ = 1'b1
  - helper for SEL_W derivation
  - localparam MAX_NUM_IN = 64
- One natural sub-module, mux_n_seq_pipe: a LATENCY-deep DATA_W+1-bit delay line (data plus valid bit), reused for out0 and out_valid.
- Channel selection and sequencer stay in the top module.

Test Plan:
- Reset: drive rst=0 with random inputs -> out0=0, out_valid=0, cur_chan=0 after one edge; stays 0 while rst=0.
- Static: NUM_IN=8, LATENCY=2, run with sel=5 mode=0, in ch5=0xA5A5A5A5, running=1 -> out0=0xA5A5A5A5 and out_valid=1 exactly 2 cycles after running rises.
- Sequence: sel=2, seq_end=4, period=1, mode=1 -> cur_chan 2,2,3,3,4,4,2,2...; out0 follows with LATENCY delay.
- Wrap: sel=6, seq_end=1, period=0 -> cur_chan 6,7,0,1,6; running low for 3 cycles freezes cur_chan; out_valid drops after LATENCY cycles.
- Run collision: run pulse with sel=3 on the same cycle as an advance from 4 -> cur_chan=3 and counter=0 next cycle.
- Out-of-range: NUM_IN=6, sel=7 -> with macro out0 = in ch5, without macro out0 = 0.

Source files
------------

// File: rtl/mux_n_seq_pkg.sv
// Shared definitions for the mux_n_seq functional unit: select-mode
// encodings, channel-count ceiling and the channel-index width helper.
package mux_n_seq_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;

    localparam int MAX_NUM_IN = 64;

    // Channel index width; a 2-input mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_seq_pipe.sv
// Fixed-depth delay line for the mux output: DATA_W data bits plus one
// valid bit travel together so out0 and out_valid stay aligned.
module mux_n_seq_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W:0]   i_data,
    output logic [DATA_W:0]   o_data
);

    logic [DATA_W:0] r_stage [LATENCY];

    // Shift every stage each cycle; reset clears the whole line at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < LATENCY; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_data = r_stage[LATENCY-1];

endmodule

// File: rtl/mux_n_seq.sv
// mux_n_seq: NUM_IN-channel registered mux with a static select mode and
// an autonomous channel sequencer that dwells period+1 cycles per channel.
// Optional build macro MUX_N_SEQ_SEL_CLAMP_EN: out-of-range channel indices
// select the last channel and the sequence end is clamped to NUM_IN-1;
// without it an out-of-range index selects all-zero data.
module mux_n_seq
    import mux_n_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_IN   = 8,
    parameter int LATENCY  = 1,
    parameter int PERIOD_W = 8,
    localparam int SEL_W   = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     running,
    input  logic                     run,
    input  logic [DATA_W*NUM_IN-1:0] in_flat,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [SEL_W-1:0]         seq_end,
    (* versat_latency = LATENCY *)
    output logic [DATA_W-1:0]        out0,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         cur_chan
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    // Shadow configuration, captured on run
    logic [SEL_W-1:0]    r_sel_q;
    logic                r_mode_q;
    logic [PERIOD_W-1:0] r_period_q;
    logic [SEL_W-1:0]    r_end_q;

    // Sequencer state
    logic [SEL_W-1:0]    r_cur_chan;
    logic [PERIOD_W-1:0] r_dwell;

    logic [DATA_W-1:0]   w_chan [NUM_IN];
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_oob_data;
    logic [SEL_W-1:0]    w_end_eff;
    logic [SEL_W-1:0]    w_next_chan;
    logic                w_dwell_done;
    logic [DATA_W:0]     w_pipe_out;

    // Unpack the flat input bus into one word per channel.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign w_chan[gi] = in_flat[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef MUX_N_SEQ_SEL_CLAMP_EN
    // Out-of-range index reads the last channel; the wrap point never
    // lies beyond the last real channel.
    assign w_oob_data = w_chan[NUM_IN-1];
    assign w_end_eff  = (r_end_q > LAST_CH) ? LAST_CH : r_end_q;
`else
    // Out-of-range index reads zero; the wrap point is used as configured.
    assign w_oob_data = '0;
    assign w_end_eff  = r_end_q;
`endif

    // Channel select: any index that matches no real channel falls back
    // to the out-of-range data word.
    always_comb begin
        w_sel_data = w_oob_data;
        for (int k = 0; k < NUM_IN; k++) begin
            if (r_cur_chan == SEL_W'(k)) begin
                w_sel_data = w_chan[k];
            end
        end
    end

    // Next channel in the window: end wraps back to start, and the top
    // channel rolls over to 0 so windows with end < start still work.
    always_comb begin
        if (r_cur_chan == w_end_eff) begin
            w_next_chan = r_sel_q;
        end else if (r_cur_chan == LAST_CH) begin
            w_next_chan = '0;
        end else begin
            w_next_chan = r_cur_chan + SEL_W'(1);
        end
    end

    assign w_dwell_done = (r_dwell == r_period_q);

    // Config shadowing and channel sequencer; run takes precedence over
    // an advance on the same edge so the sequence restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel_q    <= '0;
            r_mode_q   <= MODE_STATIC;
            r_period_q <= '0;
            r_end_q    <= '0;
            r_cur_chan <= '0;
            r_dwell    <= '0;
        end else if (run) begin
            r_sel_q    <= sel;
            r_mode_q   <= mode;
            r_period_q <= period;
            r_end_q    <= seq_end;
            r_cur_chan <= sel;
            r_dwell    <= '0;
        end else if ((r_mode_q == MODE_SEQ) && running) begin
            if (w_dwell_done) begin
                r_dwell    <= '0;
                r_cur_chan <= w_next_chan;
            end else begin
                r_dwell    <= r_dwell + PERIOD_W'(1);
            end
        end
    end

    // Output delay line carries the selected word with running as valid.
    mux_n_seq_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_data ({running, w_sel_data}),
        .o_data (w_pipe_out)
    );

    assign out0      = w_pipe_out[DATA_W-1:0];
    assign out_valid = w_pipe_out[DATA_W];
    assign cur_chan  = r_cur_chan;

endmodule
